// File: rtl/light_adc_sampler_pkg.sv
`default_nettype none
// ============================================================================
// light_adc_sampler_pkg
// MCP3002 framing constants and the SPI sequencer state encoding.
// Revision: 1.0
// ============================================================================
package light_adc_sampler_pkg;

    localparam logic CFG_START    = 1'b1;
    localparam logic CFG_SGL      = 1'b1;
    localparam logic CFG_MSBF     = 1'b1;
    localparam int   NULL_BIT_IDX = 4;
    localparam int   FRAME_BITS   = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Command word presented on din, one bit per SCLK period; zero after MSBF.
    function automatic logic cfg_bit(input logic [3:0] idx, input logic odd);
        case (idx)
            4'd0:    cfg_bit = CFG_START;
            4'd1:    cfg_bit = CFG_SGL;
            4'd2:    cfg_bit = odd;
            4'd3:    cfg_bit = CFG_MSBF;
            default: cfg_bit = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/light_adc_sampler_avg_filter.sv
`default_nettype none
// ============================================================================
// light_avg_filter
// Sliding-window mean over the last 2**AVG_LOG2 samples (ring buffer + running sum).
// Revision: 1.0
// ============================================================================
module light_avg_filter #(
    parameter int DATA_W   = 10,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] level,
    output logic              level_valid
);

    localparam int N      = 1 << AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    logic [DATA_W-1:0] ring [N];
    logic [PTR_W-1:0]  wr_ptr;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_nxt;
    logic              full_nxt;

    // The oldest entry is always part of sum, so the subtraction cannot underflow.
    assign sum_nxt  = sum + SUM_W'(in_data) - SUM_W'(ring[wr_ptr]);
    assign fill_nxt = (fill == FILL_W'(N)) ? fill : fill + 1'b1;
    assign full_nxt = (fill_nxt == FILL_W'(N));

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            sum    <= '0;
            fill   <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < N; i++) begin
                ring[i] <= '0;
            end
        end else if (in_valid) begin
            sum          <= sum_nxt;
            fill         <= fill_nxt;
            ring[wr_ptr] <= in_data;
            wr_ptr       <= (wr_ptr == PTR_W'(N - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Level survives a clear; only reset forces it back to zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (in_valid && !clear && full_nxt) begin
                level       <= sum_nxt[SUM_W-1:AVG_LOG2];
                level_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/light_adc_sampler.sv
`default_nettype none
// ============================================================================
// light_adc_sampler
// MCP3002 SPI master with continuous conversion and a windowed-mean light level.
// Revision: 1.0
// ============================================================================
module light_adc_sampler #(
    parameter int SCLK_DIV  = 10000,
    parameter int FRAME_GAP = 2,
    parameter int AVG_LOG2  = 2,
    parameter int DATA_W    = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              channel,
    input  logic              adc_dout,
    output logic              adc_cs,
    output logic              adc_sclk,
    output logic              adc_din,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic [DATA_W-1:0] light_level,
    output logic              level_valid
);

    import light_adc_sampler_pkg::*;

    localparam int         TICK_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int         GAP_TICKS  = 2 * FRAME_GAP;
    localparam int         GAP_W      = $clog2(GAP_TICKS + 1);
    localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);
    localparam logic [3:0] FIRST_DATA = 4'(NULL_BIT_IDX + 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    state_t            state, state_nxt;
    logic              cs_nxt, sclk_nxt, din_nxt;
    logic [3:0]        bit_idx, bit_idx_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [DATA_W-1:0] result, result_nxt;
    logic [DATA_W-1:0] sample_nxt;
    logic              sample_valid_nxt;
    logic              chan_lat, chan_lat_nxt;
    logic              frame_start;

    assign tick = enable && (tick_cnt == TICK_W'(SCLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign frame_start = (state == ST_IDLE) ||
                         ((state == ST_GAP) && (gap_cnt == GAP_W'(GAP_TICKS - 1)));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            adc_cs       <= 1'b1;
            adc_sclk     <= 1'b0;
            adc_din      <= 1'b0;
            bit_idx      <= '0;
            gap_cnt      <= '0;
            result       <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            chan_lat     <= 1'b0;
        end else begin
            state        <= state_nxt;
            adc_cs       <= cs_nxt;
            adc_sclk     <= sclk_nxt;
            adc_din      <= din_nxt;
            bit_idx      <= bit_idx_nxt;
            gap_cnt      <= gap_cnt_nxt;
            result       <= result_nxt;
            sample       <= sample_nxt;
            sample_valid <= sample_valid_nxt;
            chan_lat     <= chan_lat_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cs_nxt           = adc_cs;
        sclk_nxt         = adc_sclk;
        din_nxt          = adc_din;
        bit_idx_nxt      = bit_idx;
        gap_cnt_nxt      = gap_cnt;
        result_nxt       = result;
        sample_nxt       = sample;
        sample_valid_nxt = 1'b0;
        chan_lat_nxt     = chan_lat;

        if (!enable) begin
            // Abort: the partial frame is dropped without publishing a sample.
            state_nxt = ST_IDLE;
            cs_nxt    = 1'b1;
            sclk_nxt  = 1'b0;
            din_nxt   = 1'b0;
        end else if (tick) begin
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (frame_start) begin
                        state_nxt    = ST_SETUP;
                        cs_nxt       = 1'b0;
                        din_nxt      = cfg_bit(4'd0, channel);
                        chan_lat_nxt = channel;
                        bit_idx_nxt  = '0;
                        result_nxt   = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!adc_sclk) begin
                        sclk_nxt = 1'b1;
                        if (bit_idx >= FIRST_DATA) begin
                            result_nxt = {result[DATA_W-2:0], adc_dout};
                        end
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_idx == LAST_BIT) begin
                            state_nxt        = ST_GAP;
                            cs_nxt           = 1'b1;
                            din_nxt          = 1'b0;
                            gap_cnt_nxt      = '0;
                            sample_nxt       = result;
                            sample_valid_nxt = 1'b1;
                        end else begin
                            bit_idx_nxt = bit_idx + 4'd1;
                            din_nxt     = cfg_bit(bit_idx + 4'd1, chan_lat);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cs_nxt    = 1'b1;
                    sclk_nxt  = 1'b0;
                    din_nxt   = 1'b0;
                end
            endcase
        end
    end

    light_avg_filter #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_filter (
        .clk         (clk),
        .rstn        (rstn),
        .clear       (!enable),
        .in_valid    (sample_valid),
        .in_data     (sample),
        .level       (light_level),
        .level_valid (level_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_light_adc_sampler.sv
`default_nettype none
// ============================================================================
// tb_light_adc_sampler
// Directed bench with a behavioural MCP3002 model and hand-computed expectations.
// Revision: 1.0
// ============================================================================
module tb_light_adc_sampler;

    localparam int SCLK_DIV   = 2;
    localparam int FRAME_GAP  = 1;
    localparam int AVG_LOG2   = 2;
    localparam int DATA_W     = 10;
    localparam int FRAME_CLKS = 66;  // (1 + 30 + 2) ticks * 2 clks
    localparam int GAP_CLKS   = 4;   // 2 idle ticks * 2 clks

    logic clk      = 1'b0;
    logic rstn     = 1'b0;
    logic enable   = 1'b0;
    logic channel  = 1'b0;
    logic adc_dout = 1'b0;
    wire              adc_cs, adc_sclk, adc_din, sample_valid, level_valid;
    wire [DATA_W-1:0] sample, light_level;

    int n_tests  = 0;
    int n_fail   = 0;
    int sv_count = 0;
    int lv_count = 0;

    logic [9:0] adc_val   = '0;
    logic [9:0] dsr       = '0;
    logic [3:0] cfg_cap   = '0;
    int         rise_cnt  = 0;
    int         fall_cnt  = 0;
    logic       prev_cs   = 1'b1;
    logic       prev_sclk = 1'b0;

    always #5 clk = ~clk;

    light_adc_sampler #(
        .SCLK_DIV  (SCLK_DIV),
        .FRAME_GAP (FRAME_GAP),
        .AVG_LOG2  (AVG_LOG2),
        .DATA_W    (DATA_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .channel      (channel),
        .adc_dout     (adc_dout),
        .adc_cs       (adc_cs),
        .adc_sclk     (adc_sclk),
        .adc_din      (adc_din),
        .sample       (sample),
        .sample_valid (sample_valid),
        .light_level  (light_level),
        .level_valid  (level_valid)
    );

    // ADC model: captures din on SCLK rise, presents D9..D0 after falls 5..14.
    always @(negedge clk) begin
        if (sample_valid) sv_count++;
        if (level_valid)  lv_count++;
        if (prev_cs && !adc_cs) begin
            dsr      = adc_val;
            cfg_cap  = '0;
            rise_cnt = 0;
            fall_cnt = 0;
            adc_dout = 1'b0;
        end
        if (!adc_cs && !prev_sclk && adc_sclk) begin
            if (rise_cnt < 4) cfg_cap = {cfg_cap[2:0], adc_din};
            rise_cnt++;
        end
        if (!adc_cs && prev_sclk && !adc_sclk) begin
            fall_cnt++;
            if (fall_cnt >= 5 && fall_cnt <= 14) begin
                adc_dout = dsr[9];
                dsr      = {dsr[8:0], 1'b0};
            end else begin
                adc_dout = 1'b0;
            end
        end
        prev_cs   = adc_cs;
        prev_sclk = adc_sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_sv(input string tag, output int clks);
        logic seen;
        seen = 1'b0;
        clks = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            clks++;
            if (sample_valid) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_rise(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (!adc_cs && rise_cnt == n) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"},    32'(adc_cs),       32'd1);
        check({tag, "_sclk"},  32'(adc_sclk),     32'd0);
        check({tag, "_din"},   32'(adc_din),      32'd0);
        check({tag, "_smp"},   32'(sample),       32'd0);
        check({tag, "_lvl"},   32'(light_level),  32'd0);
        check({tag, "_sv"},    32'(sample_valid), 32'd0);
        check({tag, "_lv"},    32'(level_valid),  32'd0);
    endtask

    initial begin : main
        int clks, gap, sv_base, lv_base;
        logic [9:0] vals [5];
        logic [9:0] lvls [5];
        vals = '{10'd800, 10'd800, 10'd800, 10'd804, 10'd0};
        lvls = '{10'd0,   10'd0,   10'd0,   10'd801, 10'd601};

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Frame 1: channel 0, 0x2A5
        rstn    = 1'b1;
        enable  = 1'b1;
        channel = 1'b0;
        adc_val = 10'h2A5;
        wait_sv("f1", clks);
        channel = 1'b1;
        adc_val = 10'h3FF;
        check("f1_sample", 32'(sample),   32'h2A5);
        check("f1_cfg",    32'(cfg_cap),  32'b1101);
        check("f1_rises",  32'(rise_cnt), 32'd15);
        check("f1_cs_hi",  32'(adc_cs),   32'd1);
        gap = 0;
        for (int i = 0; i < 20 && adc_cs; i++) begin
            @(negedge clk);
            gap++;
        end
        check("gap_clks", 32'(gap), 32'(GAP_CLKS));

        // Frame 2: channel 1, full scale
        wait_sv("f2", clks);
        adc_val = 10'h000;
        check("frame_clks", 32'(clks + gap), 32'(FRAME_CLKS));
        check("f2_sample",  32'(sample),     32'h3FF);
        check("f2_cfg",     32'(cfg_cap),    32'b1111);

        // Frame 3: zero; channel flips mid-frame and must not affect it
        repeat (20) @(negedge clk);
        channel = 1'b0;
        wait_sv("f3", clks);
        adc_val = 10'h123;
        check("f3_sample", 32'(sample),      32'h000);
        check("f3_cfg",    32'(cfg_cap),     32'b1111);
        check("f3_no_lv",  32'(lv_count),    32'd0);
        check("f3_lvl",    32'(light_level), 32'd0);

        // Frame 4 aborted at bit_idx 7
        wait_rise("f4", 8);
        check("f4_cfg", 32'(cfg_cap), 32'b1101);
        enable = 1'b0;
        @(negedge clk);
        check("abort_cs",   32'(adc_cs),   32'd1);
        check("abort_sclk", 32'(adc_sclk), 32'd0);
        check("abort_din",  32'(adc_din),  32'd0);
        sv_base = sv_count;
        repeat (80) @(negedge clk);
        check("abort_no_sv",   32'(sv_count),    32'(sv_base));
        check("abort_smp_hld", 32'(sample),      32'h000);
        check("abort_lvl_hld", 32'(light_level), 32'd0);

        // Refill the window after re-enable
        enable  = 1'b1;
        adc_val = vals[0];
        lv_base = lv_count;
        for (int k = 0; k < 5; k++) begin
            wait_sv($sformatf("avg%0d", k), clks);
            if (k < 4) begin
                adc_val = vals[k+1];
            end else begin
                adc_val = 10'h155;
                channel = 1'b1;
            end
            check($sformatf("avg%0d_sample", k), 32'(sample), 32'(vals[k]));
            check($sformatf("avg%0d_lv_early", k), 32'(level_valid), 32'd0);
            if (k == 0) check("avg0_cfg", 32'(cfg_cap), 32'b1101);
            if (k < 3) begin
                check($sformatf("avg%0d_no_lv", k), 32'(lv_count), 32'(lv_base));
            end else begin
                @(negedge clk);
                check($sformatf("avg%0d_lv", k),  32'(level_valid), 32'd1);
                check($sformatf("avg%0d_lvl", k), 32'(light_level), 32'(lvls[k]));
            end
        end

        // Reset pulse mid-SHIFT, then a normal frame
        wait_rise("f6", 6);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rstn    = 1'b1;
        lv_base = lv_count;
        wait_sv("f6", clks);
        check("f6_sample", 32'(sample),   32'h155);
        check("f6_cfg",    32'(cfg_cap),  32'b1111);
        check("f6_rises",  32'(rise_cnt), 32'd15);
        repeat (10) @(negedge clk);
        check("f6_no_lv",  32'(lv_count), 32'(lv_base));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
